// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types and constants for the 16-bit SRAM controller.
//                Holds the access FSM state enum, the SRAM bus widths and
//                the default base address / access length.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } sram_state_t;

    localparam int SRAM_AW           = 18;
    localparam int SRAM_DW           = 16;
    localparam int DEF_BASE_ADDR     = 1024;
    localparam int DEF_ACCESS_CYCLES = 6;

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage responder that turns one 32-bit load/store request
//                into two halfword accesses on an external asynchronous
//                16-bit SRAM, holding ready low (pipeline freeze) until the
//                access completes. Little-endian word layout: the low
//                halfword lives at the even SRAM address.
//                Optional macro SRAM_RANGE_CHECK_EN adds an out-of-range /
//                misaligned address check with a sticky addr_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_pkg::*;
#(
    parameter int BASE_ADDR     = DEF_BASE_ADDR,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int CW = $clog2(ACCESS_CYCLES);
    // Last WAIT count value; unused when WAIT is skipped (ACCESS_CYCLES == 4)
    localparam logic [CW-1:0] WAIT_LAST = CW'((ACCESS_CYCLES > 4) ? ACCESS_CYCLES - 5 : 0);

    sram_state_t        state;
    sram_state_t        next_state;
    logic [CW-1:0]      cnt;
    logic               req;
    logic               start_ok;
    logic [31:0]        offset;
    logic               op_write;
    logic [16:0]        op_idx;
    logic [31:0]        op_data;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;

    assign req    = wr_en | rd_en;
    assign offset = address - 32'(BASE_ADDR);
    assign ready  = ~req | (state == DONE);

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

`ifdef SRAM_RANGE_CHECK_EN
    logic bad;
    logic unused_bits;
    // Offset must fall inside the 512 KiB SRAM window and be word aligned
    assign bad         = (offset[31:19] != 13'd0) | (address[1:0] != 2'd0);
    assign start_ok    = ~bad;
    assign unused_bits = ^offset[1:0];
`else
    logic unused_bits;
    assign start_ok    = 1'b1;
    assign unused_bits = ^{offset[31:19], offset[1:0]};
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = start_ok ? LO : DONE;
            LO:   next_state = HI;
            HI:   next_state = (ACCESS_CYCLES == 4) ? DONE : WAIT;
            WAIT: if (cnt == WAIT_LAST) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // WAIT-state cycle counter, cleared whenever not waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               cnt <= '0;
        else if (state == WAIT) cnt <= cnt + 1'b1;
        else                    cnt <= '0;
    end

    // Latch the request when it is accepted in IDLE; write wins over read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write <= 1'b0;
            op_idx   <= '0;
            op_data  <= '0;
        end else if (state == IDLE && req) begin
            op_write <= wr_en;
            op_idx   <= offset[18:2];
            op_data  <= write_data;
        end
    end

    // SRAM pins are registered from the next state so they are glitch-free
    // for the whole LO/HI cycle; the LO halfword comes straight from inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (next_state)
                LO: begin
                    SRAM_ADDR <= {offset[18:2], 1'b0};
                    SRAM_WE_N <= ~wr_en;
                    dq_oe     <= wr_en;
                    dq_out    <= write_data[15:0];
                end
                HI: begin
                    SRAM_ADDR <= {op_idx, 1'b1};
                    SRAM_WE_N <= ~op_write;
                    dq_oe     <= op_write;
                    dq_out    <= op_data[31:16];
                end
                default: begin
                    SRAM_WE_N <= 1'b1;
                    dq_oe     <= 1'b0;
                end
            endcase
        end
    end

    // Capture read halfwords at the end of LO/HI; writes leave read_data alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else begin
            if (state == LO && !op_write)      read_data[15:0]  <= SRAM_DQ;
            else if (state == HI && !op_write) read_data[31:16] <= SRAM_DQ;
`ifdef SRAM_RANGE_CHECK_EN
            if (state == IDLE && req && bad && !wr_en) read_data <= '0;
`endif
        end
    end

`ifdef SRAM_RANGE_CHECK_EN
    // Sticky range error, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           addr_err <= 1'b0;
        else if (state == IDLE && req && bad) addr_err <= 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Self-checking bench for sram_controller with a behavioural
//                256Kx16 SRAM on the data bus and a word-level reference
//                memory. Range-check cases run when SRAM_RANGE_CHECK_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int BASE = 1024;
    localparam int AC   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         sram_we_n;
    wire         sram_ub_n;
    wire         sram_lb_n;
    wire         sram_ce_n;
    wire         sram_oe_n;
`ifdef SRAM_RANGE_CHECK_EN
    wire         addr_err;
`endif

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n)
`ifdef SRAM_RANGE_CHECK_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: drives the bus whenever not written
    logic [15:0] mem [0:262143];
    bit          init_done;
    logic        pl_en = 1'b0;
    logic [17:0] pl_a  = '0;
    logic [15:0] pl_d  = '0;

    assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
            init_done = 1'b1;
        end
        if (!sram_we_n) mem[sram_addr] = sram_dq;
        if (pl_en)      mem[pl_a]      = pl_d;
    end

    // Word-level reference memory, indexed by word offset from BASE
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd;
    logic [17:0] exp_addr;
    int          written[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] model_word(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        @(negedge clk); #1;
        pl_en = 1'b0;
        @(posedge clk); #2;
    endtask

    // One full access starting from IDLE (called just after a rising edge)
    task automatic access(input logic w, input logic r, input logic [31:0] addr,
                          input logic [31:0] data);
        int          idx;
        logic [17:0] lo;
        logic [31:0] exp_word;
        idx      = int'(((addr - 32'(BASE)) >> 2) & 32'h1FFFF);
        lo       = 18'(idx * 2);
        exp_word = w ? data : model_word(idx);
        wr_en = w; rd_en = r; address = addr; write_data = data;
        #1 chk("ready_c0", {31'd0, ready}, 32'd0);
        for (int c = 1; c < AC; c++) begin
            @(posedge clk); #2;
            chk($sformatf("ready_c%0d", c), {31'd0, ready}, {31'd0, c == AC - 1});
            if (c == 1) begin
                chk("addr_lo", {14'd0, sram_addr}, {14'd0, lo});
                chk("we_lo", {31'd0, sram_we_n}, {31'd0, ~w});
                if (w) chk("dq_lo", {16'd0, sram_dq}, {16'd0, data[15:0]});
            end else if (c == 2) begin
                chk("addr_hi", {14'd0, sram_addr}, {14'd0, lo + 18'd1});
                chk("we_hi", {31'd0, sram_we_n}, {31'd0, ~w});
                if (w) chk("dq_hi", {16'd0, sram_dq}, {16'd0, data[31:16]});
            end else begin
                chk("we_wait", {31'd0, sram_we_n}, 32'd1);
                chk("rdata_mid", read_data, w ? exp_rd : exp_word);
            end
        end
        if (w) begin
            ref_mem[idx] = data;
            written.push_back(idx);
            chk("sram_image", {mem[lo + 18'd1], mem[lo]}, data);
        end else begin
            exp_rd = exp_word;
        end
        exp_addr = lo + 18'd1;
        wr_en = 1'b0; rd_en = 1'b0;
        #1 chk("ready_drop", {31'd0, ready}, 32'd1);
        @(posedge clk); #2;
    endtask

`ifdef SRAM_RANGE_CHECK_EN
    task automatic err_access(input logic w, input logic [31:0] addr);
        wr_en = w; rd_en = ~w; address = addr; write_data = $urandom;
        #1 chk("err_ready_c0", {31'd0, ready}, 32'd0);
        @(posedge clk); #2;
        chk("err_ready_c1", {31'd0, ready}, 32'd1);
        chk("err_we", {31'd0, sram_we_n}, 32'd1);
        chk("err_addr_hold", {14'd0, sram_addr}, {14'd0, exp_addr});
        chk("err_flag", {31'd0, addr_err}, 32'd1);
        if (!w) exp_rd = 32'h0;
        chk("err_rdata", read_data, exp_rd);
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #2;
    endtask
`endif

    initial begin
        logic [31:0] d;
        int          idx;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        exp_rd = 32'h0; exp_addr = 18'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we", {31'd0, sram_we_n}, 32'd1);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
`ifdef SRAM_RANGE_CHECK_EN
        chk("rst_err", {31'd0, addr_err}, 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #2;

        // Idle: the SRAM model alone owns the bus
        preload(18'd0, 16'hA5C3);
        ref_mem[0] = 32'h0000A5C3;
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_we", {31'd0, sram_we_n}, 32'd1);
        chk("idle_dq", {16'd0, sram_dq}, 32'h0000A5C3);

        // Directed write / readback
        access(1'b1, 1'b0, 32'd1024, 32'h12345678);
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("rd_1024", read_data, 32'h12345678);

        preload(18'd4, 16'hBEEF);
        preload(18'd5, 16'hDEAD);
        ref_mem[2] = 32'hDEADBEEF;
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("rd_1032", read_data, 32'hDEADBEEF);

        // Both enables: the write wins, read_data untouched
        d = $urandom;
        access(1'b1, 1'b1, 32'd1028, d);
        chk("both_rdata", read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("both_readback", read_data, d);

        // Randomised traffic against the reference memory
        for (int n = 0; n < 16; n++) begin
            if (written.size() > 0 && $urandom_range(0, 1) == 1)
                idx = written[$urandom_range(0, written.size() - 1)];
            else
                idx = int'($urandom_range(0, 131071));
            if ($urandom_range(0, 1) == 1)
                access(1'b1, 1'b0, 32'(BASE + idx * 4), $urandom);
            else
                access(1'b0, 1'b1, 32'(BASE + idx * 4), 32'h0);
        end

        // Reset during cycle 2 of a write: low halfword may land, high must not
        d = $urandom;
        idx = 200;
        wr_en = 1'b1; address = 32'(BASE + idx * 4); write_data = d;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mrst_we", {31'd0, sram_we_n}, 32'd1);
        chk("mrst_addr", {14'd0, sram_addr}, 32'd0);
        chk("mrst_rdata", read_data, 32'd0);
        chk("mrst_ready_req", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        #1 chk("mrst_ready_idle", {31'd0, ready}, 32'd1);
        ref_mem[idx] = {model_word(idx)[31:16], d[15:0]};
        exp_rd = 32'h0; exp_addr = 18'd0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("partial_lo", {16'd0, mem[400]}, {16'd0, d[15:0]});
        access(1'b0, 1'b1, 32'(BASE + idx * 4), 32'h0);

`ifdef SRAM_RANGE_CHECK_EN
        err_access(1'b0, 32'd512);
        err_access(1'b1, 32'd1026);
        err_access(1'b0, 32'(BASE + (1 << 19)));
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
